// File: rtl/mux_scan_sequencer.sv
// Serialises one byte per frame into an 8:1 selector by stepping sel. Optional SCAN_MSB_FIRST_EN scans 7..0.
// Latency: first bit visible 1 cycle after load. Backpressure: bit_ready=0 freezes sel/data; loads only in IDLE or final bit.
module mux_scan_sequencer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  output logic [7:0] data_hold,
  output logic [2:0] sel,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       frame_first,
  output logic       frame_last
);

`ifdef SCAN_MSB_FIRST_EN
  localparam logic [2:0] FIRST_IDX = 3'd7;
  localparam logic [2:0] LAST_IDX  = 3'd0;
`else
  localparam logic [2:0] FIRST_IDX = 3'd0;
  localparam logic [2:0] LAST_IDX  = 3'd7;
`endif

  localparam logic       GAP_EN   = (GAP_CYCLES != 0);
  localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

  state_t     state;
  logic [3:0] gap_cnt;
  logic [2:0] sel_next;
  logic       last_bit;

`ifdef SCAN_MSB_FIRST_EN
  assign sel_next = sel - 3'd1;
`else
  assign sel_next = sel + 3'd1;
`endif

  assign last_bit = (state == SCAN) && bit_ready && (sel == LAST_IDX);

  // With no gap, the final consumed bit doubles as a load slot so frames run back-to-back.
  assign load_ready  = (state == IDLE) || (last_bit && !GAP_EN);
  assign frame_first = bit_valid && (sel == FIRST_IDX);
  assign frame_last  = bit_valid && (sel == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_hold <= 8'h00;
      sel       <= FIRST_IDX;
      bit_valid <= 1'b0;
      gap_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            data_hold <= load_data;
            sel       <= FIRST_IDX;
            bit_valid <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (bit_ready) begin
            if (sel != LAST_IDX) begin
              sel <= sel_next;
            end else if (!GAP_EN) begin
              if (load_valid) begin
                data_hold <= load_data;
                sel       <= FIRST_IDX;
              end else begin
                bit_valid <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              gap_cnt   <= GAP_INIT;
              bit_valid <= 1'b0;
              state     <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
